// File: rtl/bp_be_fe_queue_ckpt_pkg.sv
// Configuration package for the checkpointing FE->BE queue.
// It maps a processor configuration to the fe_queue packet width.
package bp_be_fe_queue_ckpt_pkg;

  typedef enum logic [1:0] {
    e_bp_inv_cfg     = 2'd0,
    e_bp_default_cfg = 2'd1
  } bp_params_e;

  function automatic int fe_queue_width(input bp_params_e cfg);
    case (cfg)
      e_bp_default_cfg: return 112;
      default:          return 64;
    endcase
  endfunction

endpackage

// File: rtl/bp_be_fe_queue_ckpt_mem.sv
// 1R1W storage array for the FE queue: synchronous write, asynchronous read.
// There is no write-to-read bypass, so a write shows up on the read port one cycle later.
module bp_be_fe_queue_ckpt_mem #(
  parameter  int width_p   = 64,
  parameter  int els_p     = 8,
  localparam int addr_w_lp = $clog2(els_p)
) (
  input  logic                 w_clk_i,
  input  logic                 w_v_i,
  input  logic [addr_w_lp-1:0] w_addr_i,
  input  logic [width_p-1:0]   w_data_i,
  input  logic [addr_w_lp-1:0] r_addr_i,
  output logic [width_p-1:0]   r_data_o
);

  logic [width_p-1:0] mem_r [els_p];

  always_ff @(posedge w_clk_i) begin
    if (w_v_i) mem_r[w_addr_i] <= w_data_i;
  end

  assign r_data_o = mem_r[r_addr_i];

endmodule

// File: rtl/bp_be_fe_queue_ckpt.sv
// Checkpointing FE->BE queue: write, issue and commit pointers over one storage array,
// so that issued-but-uncommitted packets can be replayed (roll), retired (deq) or flushed (clr).
module bp_be_fe_queue_ckpt
  import bp_be_fe_queue_ckpt_pkg::*;
#(
  parameter  bp_params_e bp_params_p       = e_bp_inv_cfg,
  parameter  int         els_p             = 8,
  localparam int         fe_queue_width_lp = fe_queue_width(bp_params_p)
) (
  input  logic                         clk_i,
  input  logic                         reset_i,
  input  logic [fe_queue_width_lp-1:0] fe_queue_i,
  input  logic                         fe_queue_v_i,
  output logic                         fe_queue_ready_o,
  output logic [fe_queue_width_lp-1:0] fe_queue_o,
  output logic                         fe_queue_v_o,
  input  logic                         fe_queue_yumi_i,
  input  logic                         fe_queue_deq_i,
  input  logic                         fe_queue_roll_i,
  input  logic                         fe_queue_clr_i
);

  localparam int ptr_w_lp = $clog2(els_p) + 1;
  localparam int idx_w_lp = ptr_w_lp - 1;

  function automatic logic [ptr_w_lp-1:0] ptr_inc(input logic [ptr_w_lp-1:0] p, input logic inc);
    return p + ptr_w_lp'(inc);
  endfunction

  // Full when the index bits match but the wrap bits differ (exactly els_p apart).
  function automatic logic ptr_full(input logic [ptr_w_lp-1:0] w, input logic [ptr_w_lp-1:0] c);
    return (w[ptr_w_lp-1] != c[ptr_w_lp-1]) && (w[idx_w_lp-1:0] == c[idx_w_lp-1:0]);
  endfunction

  logic [ptr_w_lp-1:0] wptr_r, rptr_r, cptr_r;
  logic [ptr_w_lp-1:0] wptr_n, rptr_n, cptr_n;
  logic                enq, yumi_ok, deq_ok;

  assign fe_queue_ready_o = ~ptr_full(wptr_r, cptr_r);
  assign fe_queue_v_o     = (rptr_r != wptr_r);

  assign enq     = fe_queue_v_i & fe_queue_ready_o & ~fe_queue_clr_i;
  assign yumi_ok = fe_queue_yumi_i & fe_queue_v_o;
  assign deq_ok  = fe_queue_deq_i & (cptr_r != rptr_r);

  // Commit first, then roll back to the new checkpoint, then clear down to the new read pointer.
  assign cptr_n = ptr_inc(cptr_r, deq_ok);
  assign rptr_n = fe_queue_roll_i ? cptr_n : ptr_inc(rptr_r, yumi_ok);
  assign wptr_n = fe_queue_clr_i ? rptr_n : ptr_inc(wptr_r, enq);

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wptr_r <= '0;
      rptr_r <= '0;
      cptr_r <= '0;
    end else begin
      wptr_r <= wptr_n;
      rptr_r <= rptr_n;
      cptr_r <= cptr_n;
    end
  end

  bp_be_fe_queue_ckpt_mem #(
    .width_p (fe_queue_width_lp),
    .els_p   (els_p)
  ) queue_mem (
    .w_clk_i  (clk_i),
    .w_v_i    (enq),
    .w_addr_i (wptr_r[idx_w_lp-1:0]),
    .w_data_i (fe_queue_i),
    .r_addr_i (rptr_r[idx_w_lp-1:0]),
    .r_data_o (fe_queue_o)
  );

`ifndef SYNTHESIS
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      assert (!(fe_queue_yumi_i && !fe_queue_v_o))
        else $error("fe_queue_yumi_i asserted while queue has nothing to issue");
      assert (!(fe_queue_deq_i && (cptr_r == rptr_r)))
        else $error("fe_queue_deq_i asserted with no issued entry outstanding");
    end
  end
`endif

endmodule

// File: tb/tb_bp_be_fe_queue_ckpt.sv
// Bench for the checkpointing FE->BE queue: directed scenarios plus a randomized stream,
// compared against a packet-list model (committed-onward packets plus an issued count).
module tb_bp_be_fe_queue_ckpt;
  import bp_be_fe_queue_ckpt_pkg::*;

  localparam int W   = fe_queue_width(e_bp_inv_cfg);
  localparam int ELS = 8;

  logic         clk = 1'b0;
  logic         reset_i;
  logic [W-1:0] fe_queue_i;
  logic         fe_queue_v_i;
  logic         fe_queue_ready_o;
  logic [W-1:0] fe_queue_o;
  logic         fe_queue_v_o;
  logic         fe_queue_yumi_i;
  logic         fe_queue_deq_i;
  logic         fe_queue_roll_i;
  logic         fe_queue_clr_i;

  int checks = 0;
  int errors = 0;

  // Model: mq holds every packet from the commit point onward; the first n_iss are issued.
  logic [W-1:0] mq[$];
  int           n_iss;

  bp_be_fe_queue_ckpt #(.bp_params_p(e_bp_inv_cfg), .els_p(ELS)) dut (
    .clk_i            (clk),
    .reset_i          (reset_i),
    .fe_queue_i       (fe_queue_i),
    .fe_queue_v_i     (fe_queue_v_i),
    .fe_queue_ready_o (fe_queue_ready_o),
    .fe_queue_o       (fe_queue_o),
    .fe_queue_v_o     (fe_queue_v_o),
    .fe_queue_yumi_i  (fe_queue_yumi_i),
    .fe_queue_deq_i   (fe_queue_deq_i),
    .fe_queue_roll_i  (fe_queue_roll_i),
    .fe_queue_clr_i   (fe_queue_clr_i)
  );

  always #5 clk = ~clk;

  function automatic logic m_v();
    return mq.size() > n_iss;
  endfunction

  function automatic logic m_rdy();
    return mq.size() < ELS;
  endfunction

  function automatic logic [W-1:0] m_d();
    return (mq.size() > n_iss) ? mq[n_iss] : '0;
  endfunction

  function automatic logic [W-1:0] rnd_pkt();
    return {$urandom, $urandom};
  endfunction

  task automatic do_reset();
    reset_i = 1'b1;
    fe_queue_v_i = 1'b0; fe_queue_i = '0; fe_queue_yumi_i = 1'b0;
    fe_queue_deq_i = 1'b0; fe_queue_roll_i = 1'b0; fe_queue_clr_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset_i = 1'b0;
    mq.delete();
    n_iss = 0;
  endtask

  // Drive one cycle of inputs, clock it, then advance the model by the same rules.
  task automatic cyc(input logic v, input logic [W-1:0] d, input logic y,
                     input logic dq, input logic rl, input logic cl);
    logic rdy_pre, v_pre;
    rdy_pre = m_rdy();
    v_pre   = m_v();
    fe_queue_v_i = v; fe_queue_i = d; fe_queue_yumi_i = y;
    fe_queue_deq_i = dq; fe_queue_roll_i = rl; fe_queue_clr_i = cl;
    @(posedge clk);
    #1;
    if (dq && n_iss > 0) begin
      void'(mq.pop_front());
      n_iss--;
    end
    if (rl) n_iss = 0;
    else if (y && v_pre) n_iss++;
    if (cl) while (mq.size() > n_iss) void'(mq.pop_back());
    if (v && rdy_pre && !cl) mq.push_back(d);
    fe_queue_v_i = 1'b0; fe_queue_yumi_i = 1'b0; fe_queue_deq_i = 1'b0;
    fe_queue_roll_i = 1'b0; fe_queue_clr_i = 1'b0;
  endtask

  task automatic test_reset();
    logic [W-1:0] p;
    do_reset();
    checks++;
    if (fe_queue_v_o !== 1'b0) begin
      errors++; $display("FAIL reset_v got %b want 0", fe_queue_v_o);
    end
    checks++;
    if (fe_queue_ready_o !== 1'b1) begin
      errors++; $display("FAIL reset_ready got %b want 1", fe_queue_ready_o);
    end
    // Reset in the middle of traffic.
    for (int i = 0; i < 3; i++) cyc(1'b1, rnd_pkt(), 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
    do_reset();
    checks++;
    if (fe_queue_v_o !== 1'b0 || fe_queue_ready_o !== 1'b1) begin
      errors++; $display("FAIL midreset v=%b ready=%b want v=0 ready=1", fe_queue_v_o, fe_queue_ready_o);
    end
    p = rnd_pkt();
    cyc(1'b1, p, 1'b0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (fe_queue_v_o !== 1'b1 || fe_queue_o !== p) begin
      errors++; $display("FAIL midreset_enq v=%b data=%h want v=1 data=%h", fe_queue_v_o, fe_queue_o, p);
    end
  endtask

  task automatic test_basic();
    logic [W-1:0] pk[3];
    do_reset();
    for (int i = 0; i < 3; i++) pk[i] = rnd_pkt();
    cyc(1'b1, pk[0], 1'b0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (fe_queue_v_o !== 1'b1 || fe_queue_o !== pk[0]) begin
      errors++; $display("FAIL basic_first v=%b data=%h want v=1 data=%h", fe_queue_v_o, fe_queue_o, pk[0]);
    end
    cyc(1'b1, pk[1], 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, pk[2], 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (fe_queue_v_o !== 1'b1 || fe_queue_o !== pk[i]) begin
        errors++; $display("FAIL basic_issue%0d v=%b data=%h want v=1 data=%h", i, fe_queue_v_o, fe_queue_o, pk[i]);
      end
      cyc(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
    end
    checks++;
    if (fe_queue_v_o !== 1'b0) begin
      errors++; $display("FAIL basic_empty v=%b want 0", fe_queue_v_o);
    end
  endtask

  task automatic test_full();
    logic [W-1:0] pk[ELS];
    do_reset();
    for (int i = 0; i < ELS; i++) begin
      pk[i] = rnd_pkt();
      cyc(1'b1, pk[i], 1'b0, 1'b0, 1'b0, 1'b0);
    end
    checks++;
    if (fe_queue_ready_o !== 1'b0) begin
      errors++; $display("FAIL full_ready got %b want 0", fe_queue_ready_o);
    end
    cyc(1'b1, rnd_pkt(), 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
    checks++;
    if (fe_queue_ready_o !== 1'b0) begin
      errors++; $display("FAIL full_after_yumi ready=%b want 0", fe_queue_ready_o);
    end
    cyc(1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0);
    checks++;
    if (fe_queue_ready_o !== 1'b1) begin
      errors++; $display("FAIL full_after_deq ready=%b want 1", fe_queue_ready_o);
    end
    for (int i = 1; i < ELS; i++) begin
      checks++;
      if (fe_queue_v_o !== 1'b1 || fe_queue_o !== pk[i]) begin
        errors++; $display("FAIL full_drain%0d v=%b data=%h want v=1 data=%h", i, fe_queue_v_o, fe_queue_o, pk[i]);
      end
      cyc(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
    end
    checks++;
    if (fe_queue_v_o !== 1'b0) begin
      errors++; $display("FAIL full_dropped v=%b want 0", fe_queue_v_o);
    end
  endtask

  task automatic test_roll();
    logic [W-1:0] pk[5];
    do_reset();
    for (int i = 0; i < 5; i++) begin
      pk[i] = rnd_pkt();
      cyc(1'b1, pk[i], 1'b0, 1'b0, 1'b0, 1'b0);
    end
    for (int i = 0; i < 3; i++) cyc(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (fe_queue_v_o !== 1'b1 || fe_queue_o !== pk[i]) begin
        errors++; $display("FAIL roll_replay%0d v=%b data=%h want v=1 data=%h", i, fe_queue_v_o, fe_queue_o, pk[i]);
      end
      cyc(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
    end
    checks++;
    if (fe_queue_v_o !== 1'b0) begin
      errors++; $display("FAIL roll_end v=%b want 0", fe_queue_v_o);
    end
  endtask

  task automatic test_clr();
    logic [W-1:0] p;
    do_reset();
    for (int i = 0; i < 5; i++) cyc(1'b1, rnd_pkt(), 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) cyc(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, rnd_pkt(), 1'b0, 1'b0, 1'b0, 1'b1);
    checks++;
    if (fe_queue_v_o !== 1'b0) begin
      errors++; $display("FAIL clr_v got %b want 0", fe_queue_v_o);
    end
    for (int i = 0; i < 2; i++) cyc(1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0);
    checks++;
    if (fe_queue_ready_o !== 1'b1 || fe_queue_v_o !== 1'b0) begin
      errors++; $display("FAIL clr_deq ready=%b v=%b want ready=1 v=0", fe_queue_ready_o, fe_queue_v_o);
    end
    p = rnd_pkt();
    cyc(1'b1, p, 1'b0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (fe_queue_v_o !== 1'b1 || fe_queue_o !== p) begin
      errors++; $display("FAIL clr_reenq v=%b data=%h want v=1 data=%h", fe_queue_v_o, fe_queue_o, p);
    end
  endtask

  task automatic test_deq_roll();
    logic [W-1:0] pk[5];
    do_reset();
    for (int i = 0; i < 5; i++) begin
      pk[i] = rnd_pkt();
      cyc(1'b1, pk[i], 1'b0, 1'b0, 1'b0, 1'b0);
    end
    for (int i = 0; i < 3; i++) cyc(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, '0, 1'b0, 1'b1, 1'b1, 1'b0);
    for (int i = 1; i < 5; i++) begin
      checks++;
      if (fe_queue_v_o !== 1'b1 || fe_queue_o !== pk[i]) begin
        errors++; $display("FAIL deqroll_replay%0d v=%b data=%h want v=1 data=%h", i, fe_queue_v_o, fe_queue_o, pk[i]);
      end
      cyc(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
    end
    checks++;
    if (fe_queue_v_o !== 1'b0) begin
      errors++; $display("FAIL deqroll_end v=%b want 0", fe_queue_v_o);
    end
  endtask

  task automatic test_random();
    int   sent = 0;
    int   ncyc = 0;
    logic v, y, dq, rl, cl;
    do_reset();
    while ((sent < 40 || mq.size() > 0) && ncyc < 3000) begin
      checks++;
      if (fe_queue_v_o !== m_v() || fe_queue_ready_o !== m_rdy()) begin
        errors++; $display("FAIL rand_flags cyc %0d v=%b ready=%b want v=%b ready=%b",
                           ncyc, fe_queue_v_o, fe_queue_ready_o, m_v(), m_rdy());
      end
      if (m_v()) begin
        checks++;
        if (fe_queue_o !== m_d()) begin
          errors++; $display("FAIL rand_data cyc %0d got %h want %h", ncyc, fe_queue_o, m_d());
        end
      end
      v  = (sent < 40) && ($urandom_range(0, 3) != 0);
      y  = m_v() && ($urandom_range(0, 1) == 1);
      dq = (n_iss > 0) && ($urandom_range(0, 2) == 0);
      rl = (sent < 40) && ($urandom_range(0, 9) == 0);
      cl = (sent < 40) && ($urandom_range(0, 19) == 0);
      if (v && m_rdy() && !cl) sent++;
      cyc(v, rnd_pkt(), y, dq, rl, cl);
      ncyc++;
    end
    checks++;
    if (ncyc >= 3000) begin
      errors++; $display("FAIL rand_timeout sent=%0d left=%0d want drained within 3000 cycles", sent, mq.size());
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_full();
    test_roll();
    test_clr();
    test_deq_roll();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
